// File: rtl/inst_fetch_queue_pkg.sv
// Shared defaults for the fetch front end: widths, queue depth and boot vector.
package inst_fetch_queue_pkg;
  localparam int          WORD_WIDTH    = 32;
  localparam int          FETCH_Q_DEPTH = 4;
  localparam logic [31:0] RESET_PC_DEF  = 32'hBFC0_0000;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch front-end bus: SRAM request/response, decode dequeue side and redirect input.
interface inst_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_sram_en;
  logic [ADDR_W-1:0] inst_sram_addr;
  logic [DATA_W-1:0] inst_sram_rdata;
  logic              deq_ready;
  logic              deq_valid;
  logic [DATA_W-1:0] deq_instr;
  logic [ADDR_W-1:0] deq_pc;
  logic [CNT_W-1:0]  count;

  modport master (
    input  redirect_valid, redirect_pc, inst_sram_rdata, deq_ready,
    output inst_sram_en, inst_sram_addr, deq_valid, deq_instr, deq_pc, count
  );
  modport slave (
    output redirect_valid, redirect_pc, inst_sram_rdata, deq_ready,
    input  inst_sram_en, inst_sram_addr, deq_valid, deq_instr, deq_pc, count
  );
endinterface

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Circular queue of {pc, instr} entries with flush; head entry is read straight from storage.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enqValid,
  input  logic [WIDTH-1:0] enqData,
  input  logic             deqReady,
  output logic             deqValid,
  output logic [WIDTH-1:0] deqData,
  output logic [CNT_W-1:0] count
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            head, tail;
  logic                        doEnq, doDeq;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign deqValid = (count != '0);
  assign doDeq    = deqValid && deqReady;
  assign doEnq    = enqValid && !flush;
  assign deqData  = mem[head];

  // storage is cleared on reset so the head outputs read as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (doEnq) begin
        mem[tail] <= enqData;
        tail      <= ptrInc(tail);
      end
      if (flush) begin
        head  <= tail;
        count <= '0;
      end else begin
        if (doDeq) head <= ptrInc(head);
        case ({doEnq, doDeq})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  noOverflow: assert property (@(posedge clk) disable iff (rst)
    !(doEnq && count == CNT_W'(DEPTH)));
endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues credit-limited requests to a 1-cycle inst SRAM
// and queues returned instructions with their PCs for decode.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int                ADDR_W   = WORD_WIDTH,
  parameter int                DATA_W   = WORD_WIDTH,
  parameter int                DEPTH    = FETCH_Q_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_queue_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0]        fetchPc, inflightPc, reqAddr;
  logic                     inflight, issue, enq;
  logic [CNT_W-1:0]         count;
  logic [CNT_W:0]           creditUsed;
  logic [ADDR_W+DATA_W-1:0] headEntry;

  // a dequeue in this cycle frees its slot only from the next cycle on
  assign creditUsed = (CNT_W+1)'(count) + (CNT_W+1)'(inflight);
  assign issue      = !rst && (creditUsed < (CNT_W+1)'(DEPTH));
  assign reqAddr    = bus.redirect_valid ? bus.redirect_pc : fetchPc;
  assign enq        = inflight && !bus.redirect_valid;

  assign bus.inst_sram_en   = issue;
  assign bus.inst_sram_addr = reqAddr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc    <= RESET_PC;
      inflight   <= 1'b0;
      inflightPc <= '0;
    end else begin
      inflight   <= issue;
      inflightPc <= reqAddr;
      if (issue)                   fetchPc <= reqAddr + ADDR_W'(4);
      else if (bus.redirect_valid) fetchPc <= bus.redirect_pc;
    end
  end

  fetch_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(DEPTH)) uFifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.redirect_valid),
    .enqValid (enq),
    .enqData  ({inflightPc, bus.inst_sram_rdata}),
    .deqReady (bus.deq_ready),
    .deqValid (bus.deq_valid),
    .deqData  (headEntry),
    .count    (count)
  );

  assign bus.deq_pc    = headEntry[ADDR_W+DATA_W-1:DATA_W];
  assign bus.deq_instr = headEntry[DATA_W-1:0];
  assign bus.count     = count;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: DEPTH=4 main instance plus a free-running DEPTH=2 build.
module tb_inst_fetch_queue;
  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic clk, rst;
  int   checks = 0, errors = 0;

  inst_fetch_queue_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) bus ();
  inst_fetch_queue_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(2)) bus2 ();

  inst_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'hBFC0_0000)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  inst_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(2), .RESET_PC(32'hBFC0_0000)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mdl(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // SRAM models: data for the address requested in the previous cycle
  always @(posedge clk) if (bus.inst_sram_en)  bus.inst_sram_rdata  <= mdl(bus.inst_sram_addr);
  always @(posedge clk) if (bus2.inst_sram_en) bus2.inst_sram_rdata <= mdl(bus2.inst_sram_addr);
  assign bus2.redirect_valid = 1'b0;
  assign bus2.redirect_pc    = 32'h0;
  assign bus2.deq_ready      = 1'b1;

  task automatic step();
    @(negedge clk);
  endtask

  // Hold reset for one cycle, release at a negedge; returns inside cycle 0.
  task automatic restart(input logic dr);
    rst = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.deq_ready = dr;
    step(); rst = 1'b0; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.deq_ready = 1'b1;
    step(); #1;
    checks++; if (bus.inst_sram_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", bus.inst_sram_en); end
    checks++; if (bus.deq_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b exp 0", bus.deq_valid); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    checks++; if (bus.deq_pc !== 32'h0 || bus.deq_instr !== 32'h0) begin errors++; $display("FAIL reset_head got %h/%h exp 0/0", bus.deq_pc, bus.deq_instr); end
    checks++; if (bus2.inst_sram_en !== 1'b0) begin errors++; $display("FAIL reset_en2 got %b exp 0", bus2.inst_sram_en); end
  endtask

  task automatic test_stream();
    rst = 1'b0; #1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin step(); #1; end
      checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== RPC + 32'(4*k)) begin
        errors++; $display("FAIL stream_issue k=%0d got %b/%h exp 1/%h", k, bus.inst_sram_en, bus.inst_sram_addr, RPC + 32'(4*k)); end
      if (k < 2) begin
        checks++; if (bus.deq_valid !== 1'b0) begin errors++; $display("FAIL stream_lat k=%0d dv got %b exp 0", k, bus.deq_valid); end
      end else begin
        checks++; if (bus.deq_valid !== 1'b1 || bus.deq_pc !== RPC + 32'(4*(k-2)) || bus.deq_instr !== mdl(RPC + 32'(4*(k-2)))) begin
          errors++; $display("FAIL stream_deq k=%0d got %b/%h/%h exp 1/%h/%h", k, bus.deq_valid, bus.deq_pc, bus.deq_instr, RPC + 32'(4*(k-2)), mdl(RPC + 32'(4*(k-2)))); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic expEn [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int   expCnt[6] = '{0, 0, 1, 2, 3, 4};
    restart(1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin step(); #1; end
      checks++; if (bus.inst_sram_en !== expEn[k] || bus.count !== 3'(expCnt[k])) begin
        errors++; $display("FAIL bp_fill k=%0d en/count got %b/%0d exp %b/%0d", k, bus.inst_sram_en, bus.count, expEn[k], expCnt[k]); end
      if (expEn[k]) begin
        checks++; if (bus.inst_sram_addr !== RPC + 32'(4*k)) begin errors++; $display("FAIL bp_addr k=%0d got %h exp %h", k, bus.inst_sram_addr, RPC + 32'(4*k)); end
      end
    end
    for (int k = 6; k < 14; k++) begin
      step(); bus.deq_ready = 1'b1; #1;
      checks++; if (bus.deq_valid !== 1'b1 || bus.deq_pc !== RPC + 32'(4*(k-6)) || bus.deq_instr !== mdl(RPC + 32'(4*(k-6)))) begin
        errors++; $display("FAIL bp_drain k=%0d got %b/%h/%h exp 1/%h", k, bus.deq_valid, bus.deq_pc, bus.deq_instr, RPC + 32'(4*(k-6))); end
      if (k == 6) begin
        checks++; if (bus.inst_sram_en !== 1'b0) begin errors++; $display("FAIL bp_nocredit got %b exp 0", bus.inst_sram_en); end
      end
      if (k == 7) begin
        checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== RPC + 32'd16) begin
          errors++; $display("FAIL bp_resume got %b/%h exp 1/%h", bus.inst_sram_en, bus.inst_sram_addr, RPC + 32'd16); end
      end
    end
  endtask

  task automatic test_redirect();
    restart(1'b0);
    for (int k = 1; k < 3; k++) step();
    step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h1000; #1;
    checks++; if (bus.count !== 3'd2 || bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'h1000) begin
      errors++; $display("FAIL redir_issue got cnt %0d en %b addr %h exp 2/1/00001000", bus.count, bus.inst_sram_en, bus.inst_sram_addr); end
    step(); bus.redirect_valid = 1'b0; bus.deq_ready = 1'b1; #1;
    checks++; if (bus.count !== 3'd0 || bus.deq_valid !== 1'b0 || bus.inst_sram_addr !== 32'h1004) begin
      errors++; $display("FAIL redir_flush got cnt %0d dv %b addr %h exp 0/0/00001004", bus.count, bus.deq_valid, bus.inst_sram_addr); end
    step(); #1;
    checks++; if (bus.deq_valid !== 1'b1 || bus.deq_pc !== 32'h1000 || bus.deq_instr !== mdl(32'h1000)) begin
      errors++; $display("FAIL redir_first got %b/%h/%h exp 1/00001000/%h", bus.deq_valid, bus.deq_pc, bus.deq_instr, mdl(32'h1000)); end
    step(); #1;
    checks++; if (bus.deq_valid !== 1'b1 || bus.deq_pc !== 32'h1004) begin
      errors++; $display("FAIL redir_second got %b/%h exp 1/00001004", bus.deq_valid, bus.deq_pc); end
  endtask

  task automatic test_redirect_nocredit();
    restart(1'b0);
    for (int k = 1; k < 4; k++) step();
    step(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h1000; #1;
    checks++; if (bus.count !== 3'd3 || bus.inst_sram_en !== 1'b0) begin
      errors++; $display("FAIL redirnc_hold got cnt %0d en %b exp 3/0", bus.count, bus.inst_sram_en); end
    step(); bus.redirect_valid = 1'b0; bus.deq_ready = 1'b1; #1;
    checks++; if (bus.count !== 3'd0 || bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'h1000) begin
      errors++; $display("FAIL redirnc_issue got cnt %0d en %b addr %h exp 0/1/00001000", bus.count, bus.inst_sram_en, bus.inst_sram_addr); end
    step(); #1;
    checks++; if (bus.deq_valid !== 1'b0 || bus.inst_sram_addr !== 32'h1004) begin
      errors++; $display("FAIL redirnc_next got dv %b addr %h exp 0/00001004", bus.deq_valid, bus.inst_sram_addr); end
    step(); #1;
    checks++; if (bus.deq_valid !== 1'b1 || bus.deq_pc !== 32'h1000) begin
      errors++; $display("FAIL redirnc_deq got %b/%h exp 1/00001000", bus.deq_valid, bus.deq_pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] expAddr[5] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
    restart(1'b1);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8; #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin step(); bus.redirect_valid = 1'b0; #1; end
      checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== expAddr[k]) begin
        errors++; $display("FAIL wrap_addr k=%0d got %b/%h exp 1/%h", k, bus.inst_sram_en, bus.inst_sram_addr, expAddr[k]); end
      if (k >= 2) begin
        checks++; if (bus.deq_valid !== 1'b1 || bus.deq_pc !== expAddr[k-2]) begin
          errors++; $display("FAIL wrap_deq k=%0d got %b/%h exp 1/%h", k, bus.deq_valid, bus.deq_pc, expAddr[k-2]); end
      end
    end
  endtask

  task automatic test_depth2();
    logic expEn[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic expDv[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int issN = 0, deqN = 0;
    restart(1'b1);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin step(); #1; end
      checks++; if (bus2.inst_sram_en !== expEn[k] || bus2.deq_valid !== expDv[k]) begin
        errors++; $display("FAIL d2_pattern k=%0d en/dv got %b/%b exp %b/%b", k, bus2.inst_sram_en, bus2.deq_valid, expEn[k], expDv[k]); end
      if (expEn[k]) begin
        checks++; if (bus2.inst_sram_addr !== RPC + 32'(4*issN)) begin errors++; $display("FAIL d2_addr k=%0d got %h exp %h", k, bus2.inst_sram_addr, RPC + 32'(4*issN)); end
        issN++;
      end
      if (expDv[k]) begin
        checks++; if (bus2.deq_pc !== RPC + 32'(4*deqN) || bus2.deq_instr !== mdl(RPC + 32'(4*deqN))) begin
          errors++; $display("FAIL d2_deq k=%0d got %h/%h exp %h", k, bus2.deq_pc, bus2.deq_instr, RPC + 32'(4*deqN)); end
        deqN++;
      end
    end
  endtask

  task automatic test_async_reset();
    restart(1'b1);
    for (int k = 0; k < 4; k++) step();
    #1;
    checks++; if (bus.deq_valid !== 1'b1) begin errors++; $display("FAIL arst_pre dv got %b exp 1", bus.deq_valid); end
    #1; rst = 1'b1; #1;
    checks++; if (bus.inst_sram_en !== 1'b0 || bus.deq_valid !== 1'b0 || bus.count !== 3'd0) begin
      errors++; $display("FAIL arst_ctrl got en %b dv %b cnt %0d exp 0/0/0", bus.inst_sram_en, bus.deq_valid, bus.count); end
    checks++; if (bus.deq_pc !== 32'h0 || bus.deq_instr !== 32'h0) begin
      errors++; $display("FAIL arst_head got %h/%h exp 0/0", bus.deq_pc, bus.deq_instr); end
    step(); rst = 1'b0; #1;
    checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== RPC) begin
      errors++; $display("FAIL arst_restart got %b/%h exp 1/%h", bus.inst_sram_en, bus.inst_sram_addr, RPC); end
    step(); step(); #1;
    checks++; if (bus.deq_valid !== 1'b1 || bus.deq_pc !== RPC || bus.deq_instr !== mdl(RPC)) begin
      errors++; $display("FAIL arst_deq got %b/%h/%h exp 1/%h/%h", bus.deq_valid, bus.deq_pc, bus.deq_instr, RPC, mdl(RPC)); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_nocredit();
    test_wrap();
    test_depth2();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
